// File: rtl/megnetic_freq_sched.sv
// megnetic_freq_sched: gate-window scheduler and per-channel word streamer for the magnetic frequency path
// Ports: clk_100m/log_rst_n clock and async active-low reset; cfg_single/cfg_run start requests;
//        cfg_ch_mask/cfg_interval shadowed per cycle; megnetic_freq packed 5x16 results in;
//        megnetic_freq_en gate out; m_valid/m_ready/m_ch/m_data/m_last word stream;
//        busy/done/cycle_cnt status. All outputs are registered.
module megnetic_freq_sched #(
   parameter int unsigned GATE_CYCLES   = 100000,
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic        clk_100m,
   input  logic        log_rst_n,
   input  logic        cfg_single,
   input  logic        cfg_run,
   input  logic [4:0]  cfg_ch_mask,
   input  logic [31:0] cfg_interval,
   input  logic [79:0] megnetic_freq,
   output logic        megnetic_freq_en,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [2:0]  m_ch,
   output logic [15:0] m_data,
   output logic        m_last,
   output logic        busy,
   output logic        done,
   output logic [15:0] cycle_cnt
);
   typedef enum logic [2:0] {IDLE, GATE, SETTLE, LATCH, SEND, DONE, INTERVAL} state_t;
   state_t      state, state_d;
   logic [31:0] cnt, sh_interval;
   logic [4:0]  sh_mask;
   logic [79:0] snap, bus;
   logic        xfer, load, found, more, m_valid_d, m_last_d;
   logic [2:0]  sel, m_ch_d;
   logic [15:0] m_data_d;
   int          base;

   assign xfer = m_valid & m_ready;

   always_comb begin
      state_d = state;
      case (state)
         IDLE:     state_d = (cfg_single || cfg_run) ? GATE : IDLE;
         GATE:     state_d = (cnt == GATE_CYCLES - 1) ? SETTLE : GATE;
         SETTLE:   state_d = (cnt == SETTLE_CYCLES - 1) ? LATCH : SETTLE;
         LATCH:    state_d = (|sh_mask) ? SEND : DONE;
         SEND:     state_d = (xfer && m_last) ? DONE : SEND;
         DONE:     state_d = cfg_run ? INTERVAL : IDLE;
         INTERVAL: state_d = !cfg_run ? IDLE : (cnt == sh_interval) ? GATE : INTERVAL;
         default:  state_d = IDLE;
      endcase
   end

   // Next word: lowest enabled channel at or above base. In LATCH the snapshot is
   // not yet written, so the first word comes straight from the input bus.
   always_comb begin
      base  = (state == LATCH) ? 0 : int'(m_ch) + 1;
      bus   = (state == LATCH) ? megnetic_freq : snap;
      sel   = '0;
      found = 1'b0;
      more  = 1'b0;
      for (int i = 0; i < 5; i++)
         if (sh_mask[i] && i >= base) begin
            more  = more | found;
            sel   = found ? sel : 3'(i);
            found = 1'b1;
         end
      load      = (state == LATCH && |sh_mask) || (state == SEND && xfer && !m_last);
      m_valid_d = load | (m_valid & ~xfer);
      m_ch_d    = load ? sel : m_ch;
      m_data_d  = load ? bus[{sel, 4'b0000} +: 16] : m_data;
      m_last_d  = load ? !more : m_last;
   end

   always_ff @(posedge clk_100m or negedge log_rst_n)
      if (!log_rst_n) begin
         state            <= IDLE;
         cnt              <= '0;
         sh_mask          <= '0;
         sh_interval      <= '0;
         snap             <= '0;
         megnetic_freq_en <= 1'b0;
         m_valid          <= 1'b0;
         m_ch             <= '0;
         m_data           <= '0;
         m_last           <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         cycle_cnt        <= '0;
      end else begin
         state            <= state_d;
         cnt              <= (state_d != state) ? '0 : cnt + 32'd1;
         sh_mask          <= (state_d == GATE && state != GATE) ? cfg_ch_mask : sh_mask;
         sh_interval      <= (state_d == GATE && state != GATE) ? cfg_interval : sh_interval;
         snap             <= (state == LATCH) ? megnetic_freq : snap;
         megnetic_freq_en <= state_d == GATE;
         m_valid          <= m_valid_d;
         m_ch             <= m_ch_d;
         m_data           <= m_data_d;
         m_last           <= m_last_d;
         busy             <= state_d != IDLE;
         done             <= state_d == DONE;
         cycle_cnt        <= cycle_cnt + {15'd0, state_d == DONE};
      end
endmodule

// File: tb/tb_megnetic_freq_sched.sv
// tb_megnetic_freq_sched: randomized self-checking bench for megnetic_freq_sched
module tb_megnetic_freq_sched;
   localparam int G = 20, S = 4;
   logic        clk_100m = 0, log_rst_n = 0, cfg_single = 0, cfg_run = 0, m_ready = 0;
   logic [4:0]  cfg_ch_mask = 0;
   logic [31:0] cfg_interval = 0;
   logic [79:0] megnetic_freq;
   logic        megnetic_freq_en, m_valid, m_last, busy, done;
   logic [2:0]  m_ch;
   logic [15:0] m_data, cycle_cnt;
   int cyc = 0, total = 0, passed = 0, exp_cnt = 0;
   bit mode = 0;
   logic [15:0] salt = 0;
   typedef struct {int ch; int data; bit last; int cyc;} word_t;
   word_t words[$], exp_q[$];
   int en_rise[$], done_q[$];
   int en_high = 0, valid_seen = 0, first_valid = -1, stall_err = 0;
   logic pen = 0, pv = 0, pr = 0, pl = 0;
   logic [2:0]  pch = 0;
   logic [15:0] pd = 0;

   megnetic_freq_sched #(.GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut (
      .clk_100m(clk_100m), .log_rst_n(log_rst_n), .cfg_single(cfg_single), .cfg_run(cfg_run),
      .cfg_ch_mask(cfg_ch_mask), .cfg_interval(cfg_interval), .megnetic_freq(megnetic_freq),
      .megnetic_freq_en(megnetic_freq_en), .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch),
      .m_data(m_data), .m_last(m_last), .busy(busy), .done(done), .cycle_cnt(cycle_cnt));

   always #5 clk_100m = ~clk_100m;
   always @(posedge clk_100m) cyc <= cyc + 1;

   // Wrapper model: fixed 0x1000+i, or a per-clock pattern so the latch instant is observable.
   function automatic logic [79:0] freq_at(input int c, input bit md, input logic [15:0] s);
      logic [79:0] f;
      for (int i = 0; i < 5; i++)
         f[16*i +: 16] = md ? 16'(32'(s) ^ (c * 7 + i * 4099)) : 16'(16'h1000 + i);
      return f;
   endfunction
   always_comb megnetic_freq = freq_at(cyc, mode, salt);

   always @(negedge clk_100m)
      if (!log_rst_n) begin
         pv  = 0;
         pen = 0;
      end else begin
         if (megnetic_freq_en) begin
            en_high++;
            if (!pen) en_rise.push_back(cyc);
         end
         pen = megnetic_freq_en;
         if (done) done_q.push_back(cyc);
         if (m_valid) begin
            valid_seen++;
            if (first_valid < 0) first_valid = cyc;
         end
         if (pv && !pr && (!m_valid || m_ch !== pch || m_data !== pd || m_last !== pl)) stall_err++;
         if (m_valid && m_ready) words.push_back('{int'(m_ch), int'(m_data), m_last, cyc});
         pv = m_valid; pr = m_ready; pch = m_ch; pd = m_data; pl = m_last;
      end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

   task automatic clear_mon;
      words.delete(); en_rise.delete(); done_q.delete();
      en_high = 0; valid_seen = 0; first_valid = -1; stall_err = 0;
   endtask

   task automatic build_exp(input logic [4:0] mask, input logic [79:0] snap);
      exp_q.delete();
      for (int i = 0; i < 5; i++)
         if (mask[i]) exp_q.push_back('{i, int'(snap[16*i +: 16]), 1'b0, 0});
      if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1;
   endtask

   task automatic start_single(input logic [4:0] mask, output int t);
      @(posedge clk_100m); #1;
      cfg_ch_mask = mask;
      cfg_single  = 1;
      t = cyc;
      @(posedge clk_100m); #1;
      cfg_single = 0;
   endtask

   task automatic wait_done(input int n, input int budget);
      for (int i = 0; i < budget && done_q.size() < n; i++) @(negedge clk_100m);
      repeat (2) @(negedge clk_100m);
   endtask

   task automatic test_reset;
      log_rst_n = 0;
      repeat (3) @(negedge clk_100m);
      total++;
      if ({megnetic_freq_en, m_valid, m_ch, m_data, m_last, busy, done, cycle_cnt} !== '0)
         $display("FAIL reset_outputs: got en=%b v=%b ch=%0d d=%h l=%b busy=%b done=%b cnt=%0d, all required 0",
                  megnetic_freq_en, m_valid, m_ch, m_data, m_last, busy, done, cycle_cnt);
      else passed++;
      @(posedge clk_100m); #1 log_rst_n = 1;
      repeat (3) @(negedge clk_100m);
      total++;
      if ({busy, megnetic_freq_en, m_valid} !== 3'b000)
         $display("FAIL reset_idle: got busy/en/valid=%b required 000", {busy, megnetic_freq_en, m_valid});
      else passed++;
   endtask

   task automatic test_single_full;
      int t;
      clear_mon(); mode = 0; m_ready = 1;
      start_single(5'b11111, t);
      wait_done(1, 200);
      exp_cnt++;
      build_exp(5'b11111, freq_at(0, 0, 0));
      total++;
      if (en_high !== G) $display("FAIL single_en_width: got %0d required %0d", en_high, G); else passed++;
      total++;
      if ((en_rise.size() > 0 ? en_rise[0] : -1) !== t + 1)
         $display("FAIL single_en_rise: got %0d required %0d", en_rise.size() > 0 ? en_rise[0] : -1, t + 1);
      else passed++;
      total++;
      if (words.size() !== 5) $display("FAIL single_word_count: got %0d required 5", words.size()); else passed++;
      for (int k = 0; k < words.size() && k < 5; k++) begin
         total++;
         if (words[k].ch !== k || words[k].data !== 32'h1000 + k || words[k].last !== (k == 4) || words[k].cyc !== t + 26 + k)
            $display("FAIL single_word%0d: got ch=%0d d=%h l=%b at %0d required ch=%0d d=%h l=%b at %0d",
                     k, words[k].ch, words[k].data, words[k].last, words[k].cyc, k, 32'h1000 + k, k == 4, t + 26 + k);
         else passed++;
      end
      total++;
      if (done_q.size() !== 1 || done_q[0] !== t + 31)
         $display("FAIL single_done: got %0d pulses first at %0d required 1 at %0d",
                  done_q.size(), done_q.size() > 0 ? done_q[0] : -1, t + 31);
      else passed++;
      total++;
      if (cycle_cnt !== 16'(exp_cnt)) $display("FAIL single_cycle_cnt: got %0d required %0d", cycle_cnt, exp_cnt); else passed++;
   endtask

   task automatic test_mask_stall;
      int t;
      clear_mon(); mode = 1; salt = 16'($urandom); m_ready = 0;
      start_single(5'b10100, t);
      for (int i = 0; i < 200 && done_q.size() == 0; i++) begin
         @(posedge clk_100m); #1 m_ready = ~m_ready;
      end
      m_ready = 1;
      wait_done(1, 10);
      exp_cnt++;
      build_exp(5'b10100, freq_at(t + 25, 1, salt));
      total++;
      if (words.size() !== 2) $display("FAIL stall_word_count: got %0d required 2", words.size()); else passed++;
      for (int k = 0; k < words.size() && k < 2; k++) begin
         total++;
         if (words[k].ch !== exp_q[k].ch || words[k].data !== exp_q[k].data || words[k].last !== exp_q[k].last)
            $display("FAIL stall_word%0d: got ch=%0d d=%h l=%b required ch=%0d d=%h l=%b", k,
                     words[k].ch, words[k].data, words[k].last, exp_q[k].ch, exp_q[k].data, exp_q[k].last);
         else passed++;
      end
      total++;
      if (stall_err !== 0) $display("FAIL stall_stability: got %0d unstable stalls required 0", stall_err); else passed++;
      total++;
      if (first_valid !== t + 26) $display("FAIL stall_first_valid: got %0d required %0d", first_valid, t + 26); else passed++;
      total++;
      if (cycle_cnt !== 16'(exp_cnt)) $display("FAIL stall_cycle_cnt: got %0d required %0d", cycle_cnt, exp_cnt); else passed++;
   endtask

   task automatic test_mask_zero;
      int t;
      clear_mon(); m_ready = 1;
      start_single(5'b00000, t);
      wait_done(1, 200);
      exp_cnt++;
      total++;
      if (valid_seen !== 0) $display("FAIL zero_valid: got %0d valid clocks required 0", valid_seen); else passed++;
      total++;
      if (done_q.size() !== 1 || done_q[0] !== t + 26)
         $display("FAIL zero_done: got %0d pulses first at %0d required 1 at %0d",
                  done_q.size(), done_q.size() > 0 ? done_q[0] : -1, t + 26);
      else passed++;
      total++;
      if (cycle_cnt !== 16'(exp_cnt)) $display("FAIL zero_cycle_cnt: got %0d required %0d", cycle_cnt, exp_cnt); else passed++;
   endtask

   task automatic test_run_mode;
      int t;
      clear_mon(); mode = 0; m_ready = 1;
      @(posedge clk_100m); #1;
      cfg_ch_mask = 5'b11111; cfg_interval = 10; cfg_run = 1; t = cyc;
      for (int i = 0; i < 400 && en_rise.size() < 3; i++) @(negedge clk_100m);
      @(posedge clk_100m); #1 cfg_run = 0;
      wait_done(3, 200);
      repeat (60) @(negedge clk_100m);
      exp_cnt += 3;
      total++;
      if (en_rise.size() !== 3) $display("FAIL run_cycles: got %0d gate windows required 3", en_rise.size()); else passed++;
      for (int k = 0; k < 3 && k < en_rise.size(); k++) begin
         total++;
         if (en_rise[k] !== t + 1 + 42 * k)
            $display("FAIL run_rise%0d: got %0d required %0d", k, en_rise[k], t + 1 + 42 * k);
         else passed++;
      end
      total++;
      if (done_q.size() !== 3 || words.size() !== 15)
         $display("FAIL run_done_words: got %0d done %0d words required 3 done 15 words", done_q.size(), words.size());
      else passed++;
      total++;
      if (busy !== 0 || cycle_cnt !== 16'(exp_cnt))
         $display("FAIL run_end: got busy=%b cnt=%0d required busy=0 cnt=%0d", busy, cycle_cnt, exp_cnt);
      else passed++;
   endtask

   task automatic test_reset_mid_send;
      int t;
      logic [4:0] mask;
      clear_mon(); m_ready = 0;
      start_single(5'b11111, t);
      for (int i = 0; i < 100 && !m_valid; i++) @(negedge clk_100m);
      total++;
      if (m_valid !== 1) $display("FAIL rst_reach_send: got m_valid=%b required 1", m_valid); else passed++;
      #2 log_rst_n = 0;
      #1;
      total++;
      if ({megnetic_freq_en, m_valid, m_ch, m_data, m_last, busy, done, cycle_cnt} !== '0)
         $display("FAIL rst_async_clear: got en=%b v=%b ch=%0d d=%h l=%b busy=%b done=%b cnt=%0d, all required 0",
                  megnetic_freq_en, m_valid, m_ch, m_data, m_last, busy, done, cycle_cnt);
      else passed++;
      exp_cnt = 0;
      repeat (2) @(negedge clk_100m);
      @(posedge clk_100m); #1 log_rst_n = 1;
      clear_mon(); m_ready = 1; mode = 1; salt = 16'($urandom);
      mask = 5'($urandom_range(1, 31));
      start_single(mask, t);
      wait_done(1, 200);
      exp_cnt++;
      build_exp(mask, freq_at(t + 25, 1, salt));
      total++;
      if (words.size() !== exp_q.size()) $display("FAIL rst_rerun_count: got %0d required %0d", words.size(), exp_q.size()); else passed++;
      for (int k = 0; k < words.size() && k < exp_q.size(); k++) begin
         total++;
         if (words[k].ch !== exp_q[k].ch || words[k].data !== exp_q[k].data || words[k].last !== exp_q[k].last)
            $display("FAIL rst_rerun_word%0d: got ch=%0d d=%h l=%b required ch=%0d d=%h l=%b", k,
                     words[k].ch, words[k].data, words[k].last, exp_q[k].ch, exp_q[k].data, exp_q[k].last);
         else passed++;
      end
      total++;
      if (en_high !== G || cycle_cnt !== 16'(exp_cnt) || done_q.size() !== 1 || done_q[0] !== t + 26 + exp_q.size())
         $display("FAIL rst_rerun_cycle: got en=%0d cnt=%0d done at %0d required en=%0d cnt=%0d done at %0d",
                  en_high, cycle_cnt, done_q.size() > 0 ? done_q[0] : -1, G, exp_cnt, t + 26 + exp_q.size());
      else passed++;
   endtask

   task automatic test_cfg_during_cycle;
      int t, t2;
      logic [4:0] a, b;
      clear_mon(); m_ready = 1; mode = 1; salt = 16'($urandom);
      a = 5'($urandom_range(1, 31));
      b = a ^ 5'($urandom_range(1, 31));
      if (b == 0) b = ~a;
      start_single(a, t);
      while (cyc < t + 5) begin @(posedge clk_100m); #1; end
      cfg_single = 1;
      @(posedge clk_100m); #1 cfg_single = 0;
      while (cyc < t + 22) begin @(posedge clk_100m); #1; end
      cfg_ch_mask = b;
      wait_done(1, 200);
      repeat (40) @(negedge clk_100m);
      exp_cnt++;
      build_exp(a, freq_at(t + 25, 1, salt));
      total++;
      if (en_rise.size() !== 1 || en_high !== G || done_q.size() !== 1)
         $display("FAIL ignore_single: got %0d windows %0d en clocks %0d done required 1 %0d 1",
                  en_rise.size(), en_high, done_q.size(), G);
      else passed++;
      total++;
      if (words.size() !== exp_q.size()) $display("FAIL old_mask_count: got %0d required %0d", words.size(), exp_q.size()); else passed++;
      for (int k = 0; k < words.size() && k < exp_q.size(); k++) begin
         total++;
         if (words[k].ch !== exp_q[k].ch || words[k].data !== exp_q[k].data || words[k].last !== exp_q[k].last)
            $display("FAIL old_mask_word%0d: got ch=%0d d=%h l=%b required ch=%0d d=%h l=%b", k,
                     words[k].ch, words[k].data, words[k].last, exp_q[k].ch, exp_q[k].data, exp_q[k].last);
         else passed++;
      end
      clear_mon();
      start_single(b, t2);
      wait_done(1, 200);
      exp_cnt++;
      build_exp(b, freq_at(t2 + 25, 1, salt));
      total++;
      if (words.size() !== exp_q.size()) $display("FAIL new_mask_count: got %0d required %0d", words.size(), exp_q.size()); else passed++;
      for (int k = 0; k < words.size() && k < exp_q.size(); k++) begin
         total++;
         if (words[k].ch !== exp_q[k].ch || words[k].data !== exp_q[k].data || words[k].last !== exp_q[k].last)
            $display("FAIL new_mask_word%0d: got ch=%0d d=%h l=%b required ch=%0d d=%h l=%b", k,
                     words[k].ch, words[k].data, words[k].last, exp_q[k].ch, exp_q[k].data, exp_q[k].last);
         else passed++;
      end
      total++;
      if (cycle_cnt !== 16'(exp_cnt)) $display("FAIL cfg_cycle_cnt: got %0d required %0d", cycle_cnt, exp_cnt); else passed++;
   endtask

   task automatic test_random;
      int t;
      logic [4:0] mask;
      for (int r = 0; r < 5; r++) begin
         clear_mon(); mode = 1; salt = 16'($urandom); m_ready = 1;
         mask = 5'($urandom_range(0, 31));
         start_single(mask, t);
         for (int i = 0; i < 300 && done_q.size() == 0; i++) begin
            @(posedge clk_100m); #1 m_ready = 1'($urandom_range(0, 1));
         end
         m_ready = 1;
         wait_done(1, 10);
         exp_cnt++;
         build_exp(mask, freq_at(t + 25, 1, salt));
         total++;
         if (words.size() !== exp_q.size() || done_q.size() !== 1 || stall_err !== 0)
            $display("FAIL rand%0d_shape: got %0d words %0d done %0d stall errs required %0d 1 0 (mask %b)",
                     r, words.size(), done_q.size(), stall_err, exp_q.size(), mask);
         else passed++;
         for (int k = 0; k < words.size() && k < exp_q.size(); k++) begin
            total++;
            if (words[k].ch !== exp_q[k].ch || words[k].data !== exp_q[k].data || words[k].last !== exp_q[k].last)
               $display("FAIL rand%0d_word%0d: got ch=%0d d=%h l=%b required ch=%0d d=%h l=%b", r, k,
                        words[k].ch, words[k].data, words[k].last, exp_q[k].ch, exp_q[k].data, exp_q[k].last);
            else passed++;
         end
         total++;
         if (first_valid !== (mask == 0 ? -1 : t + 26))
            $display("FAIL rand%0d_first_valid: got %0d required %0d", r, first_valid, mask == 0 ? -1 : t + 26);
         else passed++;
         total++;
         if (cycle_cnt !== 16'(exp_cnt)) $display("FAIL rand%0d_cycle_cnt: got %0d required %0d", r, cycle_cnt, exp_cnt); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_single_full();
      test_mask_stall();
      test_mask_zero();
      test_run_mode();
      test_reset_mid_send();
      test_cfg_during_cycle();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/megnetic_freq_sched.md
# megnetic_freq_sched

Measurement scheduler for the 5-channel magnetic-sensor frequency path. Runs single or periodic gate windows on the shared `megnetic_freq_en` of the frequency wrapper and snapshots the 80-bit packed result. Streams the enabled channels out one 16-bit word at a time over a valid/ready handshake to the downstream frame packer. Sits between the register/control logic and the frequency wrapper, in the `clk_100m` domain.

## Interface
- `GATE_CYCLES`, default 100000: width of the `megnetic_freq_en` gate window in clocks (1 ms at 100 MHz); must be ≥1.
- `SETTLE_CYCLES`, default 16: clocks with enable low before the snapshot, letting the measurement cores publish their final value; must be ≥1.
- `clk_100m`  in  1  system clock; the only clock.
- `log_rst_n`  in  1  asynchronous, active-low reset.
- `cfg_single`  in  1  one-clock pulse that requests one measurement cycle.
- `cfg_run`  in  1  level that requests continuous periodic measurement.
- `cfg_ch_mask`  in  5  per-channel enable for output; bit i selects channel i.
- `cfg_interval`  in  32  idle clocks between cycles in run mode.
- `megnetic_freq`  in  80  packed results; channel i is bits [16i+15:16i].
- `megnetic_freq_en`  out  1  gate/enable to the frequency wrapper.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_ch`  out  3  channel index of the current word (0–4).
- `m_data`  out  16  channel result.
- `m_last`  out  1  marks the final enabled channel of the cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-clock pulse when a cycle completes.
- `cycle_cnt`  out  16  completed-cycle counter.

## Operation
- States: IDLE, GATE, SETTLE, LATCH, SEND, DONE, INTERVAL.
- IDLE:
  - Start when `cfg_single`=1 or `cfg_run`=1.
  - On start, latch `cfg_ch_mask` and `cfg_interval` into shadow registers. These are held for the whole cycle.
  - Next state is GATE.
- GATE: `megnetic_freq_en`=1 for exactly GATE_CYCLES clocks, then go to SETTLE.
- SETTLE: `megnetic_freq_en`=0 for SETTLE_CYCLES clocks, then go to LATCH.
- LATCH (1 clock):
  - Capture all 80 bits of `megnetic_freq` into a snapshot register.
  - Go to SEND if the shadow mask is non-zero, otherwise go to DONE.
- SEND:
  - Present enabled channels in ascending index order, skipping masked-off channels with no idle clock between words.
  - `m_data`/`m_ch`/`m_last` come from the snapshot and stay stable while `m_valid`=1 and `m_ready`=0.
  - A word transfers on any clock with `m_valid`=1 and `m_ready`=1.
  - After the `m_last` transfer, go to DONE.
- DONE (1 clock):
  - `done`=1 and `cycle_cnt`+1; the counter wraps 0xFFFF→0x0000.
  - Next state is INTERVAL if `cfg_run`=1, otherwise IDLE.
- INTERVAL:
  - Count the shadow interval, then go to GATE and re-latch mask and interval.
  - Interval value 0 means go to GATE on the next clock.
  - If `cfg_run` drops during INTERVAL, go to IDLE on the next clock.
- `cfg_run` dropping in GATE, SETTLE, LATCH or SEND does not abort; the cycle completes and then returns to IDLE.
- `cfg_single` is ignored outside IDLE; it is not queued.
- `cfg_ch_mask` changes after start take effect on the next cycle.
- Reset (any state, asynchronous):
  - State returns to IDLE.
  - All outputs, counters, the snapshot and shadow registers clear to 0.
  - `megnetic_freq_en` drops immediately.
  - A word in flight is discarded.

## Timing
- All outputs are registered.
- Reset values: `megnetic_freq_en`=0, `m_valid`=0, `m_ch`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0, `cycle_cnt`=0.
- Start sampled at edge T: `busy` and `megnetic_freq_en` are high from T+1. The enable falls at T+1+GATE_CYCLES.
- Snapshot is taken at T+1+GATE_CYCLES+SETTLE_CYCLES (the LATCH clock).
- First `m_valid` is at T+2+GATE_CYCLES+SETTLE_CYCLES.
- With `m_ready` held high, N enabled channels take N clocks. `done` fires on the clock after the last transfer.
- `m_valid` never drops without a transfer, except on reset.
- Run mode period with `m_ready`=1: GATE_CYCLES+SETTLE_CYCLES+N+3+interval clocks (1 LATCH + 1 DONE + 1 INTERVAL entry, plus the interval).
- Internal counters are 32-bit.

## Test plan
All scenarios use GATE_CYCLES=20, SETTLE_CYCLES=4.

- Single shot, mask 5'b11111, `m_ready`=1, wrapper model outputs `16'h1000+i` on channel i.
  - `megnetic_freq_en` is high for exactly 20 clocks.
  - Words 0x1000…0x1004 appear with `m_ch` 0…4; `m_last` only on ch 4.
  - `done` pulses once and `cycle_cnt`=1.
- Mask 5'b10100 with `m_ready` toggling every other clock.
  - Exactly two words appear, ch 2 then ch 4 with `m_last`.
  - Data and channel stay stable during stalls; no words are duplicated.
- Mask 0: no `m_valid` at any point; `done` fires 26 clocks after start; `cycle_cnt` increments.
- Run mode, `cfg_interval`=10, `cfg_run` dropped during the third GATE.
  - Three complete cycles occur, with enable rising edges spaced 20+4+5+3+10=42 clocks apart.
  - Returns to IDLE with `cycle_cnt`=3.
- Assert `log_rst_n`=0 mid-SEND with `m_valid` high.
  - All outputs are 0 immediately.
  - A `cfg_single` after release runs a clean full cycle.
- `cfg_single` pulsed during GATE and `cfg_ch_mask` changed during SETTLE.
  - The extra pulse is ignored.
  - The current cycle uses the old mask; the next cycle uses the new one.
